lcd_text_controller: RTL and testbench
======================================

Name: lcd_text_controller

Overview:
- Generates the HD44780 16x2 character LCD pin signals (LCD_ON, LCD_RS, LCD_EN, LCD_RW, LCD_DATA) consumed by the board output wrapper.
- Holds a 32-character text buffer written by game/application logic.
- Runs the power-up init sequence, then refreshes both display lines continuously.
- Write-only to the LCD: busy flag never read, fixed delays used instead.

Parameters:
- POWERUP_CYC, 750000, clk cycles to wait after reset before the first command (15 ms at 50 MHz).
- EN_CYC, 25, cycles for each of the setup, EN-high and EN-low-hold phases (500 ns).
- CMD_CYC, 2500, post-pulse wait for normal commands and characters (50 us).
- CLR_CYC, 100000, post-pulse wait after clear display 0x01 (2 ms).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  5  character position: 0-15 line 1, 16-31 line 2.
- wr_char  in  8  ASCII code.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- frame_done  out  1  one-cycle pulse when the last character of line 2 finishes its wait.
- LCD_ON  out  1  panel power, 1 whenever not in reset.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_EN  out  1  enable strobe.
- LCD_RW  out  1  constant 0 (write).
- LCD_DATA  out  8  byte to LCD.

Behaviour:
- Reset (async, immediate) values:
  - LCD_ON=0 during reset, 1 after release.
  - LCD_RS=0, LCD_EN=0, LCD_RW=0, LCD_DATA=0x00, init_done=0, frame_done=0.
  - All 32 buffer entries set to 0x20 (space).
  - FSM returns to PWR, counters cleared.
- Buffer write: entry wr_addr updated on the clk edge where wr_en=1; visible from the next cycle. Every write is accepted; there is no backpressure.
- Byte transfer, RS and DATA held constant throughout, phases in order:
  1. SETUP: EN_CYC cycles, EN=0.
  2. PULSE: EN_CYC cycles, EN=1.
  3. WAIT: EN_CYC+CMD_CYC cycles (CLR_CYC for 0x01), EN=0.
- The next transfer's SETUP begins the cycle after WAIT ends.
- Character byte is sampled from the buffer on the first SETUP cycle. A write to that address during its transfer takes effect on the next frame.
- FSM states:
  - PWR: count POWERUP_CYC, then INIT.
  - INIT: commands 0x38, 0x0C, 0x01, 0x06 in order, RS=0. init_done rises the cycle after the 0x06 WAIT ends, then ADDR1.
  - ADDR1: command 0x80, then LINE1.
  - LINE1: entries 0-15 with RS=1, then ADDR2.
  - ADDR2: command 0xC0, then LINE2.
  - LINE2: entries 16-31 with RS=1. frame_done pulses on the final WAIT cycle of entry 31, then ADDR1 (or IDLE, see optional feature).
- Character index: 4-bit counter that wraps 15->0 at each line end.
- Wait counter: wide enough for max(POWERUP_CYC, CLR_CYC+EN_CYC).
- Reset mid-transfer: EN drops to 0 asynchronously; full power-up sequence repeats.

Optional Feature:
- Macro: LCD_DIRTY_REFRESH_EN.
- Defined:
  - A dirty flag is set by any wr_en.
  - The flag is cleared on entry to ADDR1.
  - After LINE2 the FSM enters IDLE (EN=0, outputs held). It leaves IDLE for ADDR1 when dirty=1.
  - A write during a frame causes exactly one further frame.
  - The first frame after init always runs.
- Not defined: no dirty flag, no IDLE state; frames repeat back-to-back forever.

Decomposition:
- Package lcd_pkg:
  - Command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_LINE1=0x80, CMD_LINE2=0xC0, CHAR_SPACE=0x20.
  - Top-FSM state enum.
- One sub-module, lcd_byte_writer:
  - Inputs: start, rs, data, long_wait.
  - Outputs: LCD_RS/LCD_EN/LCD_DATA, done pulse.
  - Owns the phase counter.
- Top holds the buffer, the sequencing FSM and the dirty logic.

Test Plan (POWERUP_CYC=100, EN_CYC=2, CMD_CYC=10, CLR_CYC=50):
1. Release reset -> EN=0 for 100 cycles. Then four RS=0 pulses carrying 0x38, 0x0C, 0x01, 0x06. The gap between EN falling edges after 0x01 is 2+50+2+2 cycles. init_done rises after 0x06.
2. No writes -> after init: 0x80, then 16 RS=1 bytes 0x20, then 0xC0, then 16x 0x20. frame_done pulses once, then 0x80 repeats.
3. Before init_done, write addr0=0x48 and addr17=0x69 -> first data byte of line 1 is 0x48; second data byte after 0xC0 is 0x69; all others 0x20.
4. Assert rst during LINE1 with EN=1 -> EN, RS, DATA go 0 without a clk edge, LCD_ON=0, init_done=0. After release the 100-cycle power-up wait repeats and the buffer reads all 0x20.
5. Write addr5=0x41 during SETUP of position 5 (old 0x20) -> that transfer sends 0x20; the next frame sends 0x41.
6. LCD_DIRTY_REFRESH_EN defined, no writes -> no EN pulse for 2000 cycles after the first frame_done. One write -> exactly one more frame and one frame_done, then idle again.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM encodings and the init-command table for the HD44780 text controller.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2,
    ST_IDLE
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } lcd_phase_e;

  // Power-up command order; step 3 is the last one before the first frame.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_controller_if.sv
// Character-buffer write port: application logic (master) writes into the controller (slave).
interface lcd_text_controller_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;

  modport master (output wr_en, wr_addr, wr_char);
  modport slave  (input  wr_en, wr_addr, wr_char);
endinterface

// File: rtl/lcd_byte_writer.sv
// Sends one byte to the LCD as SETUP / EN PULSE / WAIT phases with RS and DATA held throughout.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYC  = 25,
  parameter int CMD_CYC = 2500,
  parameter int CLR_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       done_o
);

  localparam int LONGEST = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int CNT_W   = $clog2(EN_CYC + LONGEST + 1);

  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(EN_CYC + CMD_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(EN_CYC + CLR_CYC - 1);

  lcd_phase_e       phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             long_q;
  logic             load;

  // A new byte may be accepted while idle or on the very last WAIT cycle, so transfers chain gap-free.
  assign load = start_i && ((phase_q == PH_IDLE) || ((phase_q == PH_WAIT) && (cnt_q == '0)));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      long_q  <= 1'b0;
    end else if (load) begin
      phase_q <= PH_SETUP;
      cnt_q   <= EN_LAST;
      rs_q    <= rs_i;
      data_q  <= data_i;
      long_q  <= long_wait_i;
    end else begin
      case (phase_q)
        PH_SETUP: begin
          if (cnt_q == '0) begin
            phase_q <= PH_PULSE;
            cnt_q   <= EN_LAST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PH_PULSE: begin
          if (cnt_q == '0) begin
            phase_q <= PH_WAIT;
            cnt_q   <= long_q ? LONG_LAST : SHORT_LAST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PH_WAIT: begin
          if (cnt_q == '0) phase_q <= PH_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // done fires one cycle early so the sequencer can present the next byte on the final WAIT cycle.
  assign done_o   = (phase_q == PH_WAIT) && (cnt_q == CNT_W'(1));
  assign LCD_EN   = (phase_q == PH_PULSE);
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;

endmodule

// File: rtl/lcd_text_controller.sv
// HD44780 16x2 text controller: 32-char buffer, power-up init, continuous two-line refresh.
// Optional LCD_DIRTY_REFRESH_EN: refresh only after buffer writes, idling between frames.
module lcd_text_controller
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int EN_CYC      = 25,
  parameter int CMD_CYC     = 2500,
  parameter int CLR_CYC     = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_text_controller_if.slave  wr_bus,
  output logic                  init_done,
  output logic                  frame_done,
  output logic                  LCD_ON,
  output logic                  LCD_RS,
  output logic                  LCD_EN,
  output logic                  LCD_RW,
  output logic [7:0]            LCD_DATA
);

  localparam int PWR_W = $clog2(POWERUP_CYC + 1);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYC - 1);

  logic [7:0]       buf_q [32];
  lcd_state_e       state_q;
  logic [PWR_W-1:0] pwr_cnt_q;
  logic [1:0]       step_q;
  logic             line_q;
  logic [3:0]       idx_q;
  logic             start_q;
  logic             rs_q;
  logic [7:0]       cmd_q;
  logic             long_q;
  logic             init_done_q;
  logic             frame_done_q;
  logic [7:0]       byte_d;
  logic             wr_done;

  // NOTE: the text buffer is reset to spaces because a blank display after reset is visible behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= CHAR_SPACE;
    end else if (wr_bus.wr_en) begin
      buf_q[wr_bus.wr_addr] <= wr_bus.wr_char;
    end
  end

  // Character bytes are read live so the writer captures the buffer as the transfer starts.
  assign byte_d = rs_q ? buf_q[{line_q, idx_q}] : cmd_q;

`ifdef LCD_DIRTY_REFRESH_EN
  logic dirty_q;
  logic dirty_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    dirty_d = dirty_q;
    if ((state_q == ST_INIT && wr_done && step_q == 2'd3) || (state_q == ST_IDLE && dirty_q))
      dirty_d = 1'b0;
    if (wr_bus.wr_en)
      dirty_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dirty_q <= 1'b0;
    else     dirty_q <= dirty_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PWR;
      pwr_cnt_q    <= '0;
      step_q       <= '0;
      line_q       <= 1'b0;
      idx_q        <= '0;
      start_q      <= 1'b0;
      rs_q         <= 1'b0;
      cmd_q        <= '0;
      long_q       <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_PWR: begin
          if (pwr_cnt_q == PWR_LAST) begin
            state_q <= ST_INIT;
            step_q  <= '0;
            start_q <= 1'b1;
            rs_q    <= 1'b0;
            cmd_q   <= init_cmd(2'd0);
            long_q  <= 1'b0;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + 1'b1;
          end
        end
        ST_INIT: begin
          if (wr_done) begin
            start_q <= 1'b1;
            if (step_q == 2'd3) begin
              state_q <= ST_ADDR1;
              cmd_q   <= CMD_LINE1;
              long_q  <= 1'b0;
            end else begin
              step_q  <= step_q + 2'd1;
              cmd_q   <= init_cmd(step_q + 2'd1);
              long_q  <= (init_cmd(step_q + 2'd1) == CMD_CLEAR);
            end
          end
        end
        ST_ADDR1: begin
          init_done_q <= 1'b1;
          if (wr_done) begin
            state_q <= ST_LINE1;
            line_q  <= 1'b0;
            idx_q   <= '0;
            rs_q    <= 1'b1;
            start_q <= 1'b1;
          end
        end
        ST_LINE1: begin
          if (wr_done) begin
            idx_q   <= idx_q + 4'd1;
            start_q <= 1'b1;
            if (idx_q == 4'd15) begin
              state_q <= ST_ADDR2;
              rs_q    <= 1'b0;
              cmd_q   <= CMD_LINE2;
            end
          end
        end
        ST_ADDR2: begin
          if (wr_done) begin
            state_q <= ST_LINE2;
            line_q  <= 1'b1;
            rs_q    <= 1'b1;
            start_q <= 1'b1;
          end
        end
        ST_LINE2: begin
          if (wr_done) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              frame_done_q <= 1'b1;
`ifdef LCD_DIRTY_REFRESH_EN
              state_q <= ST_IDLE;
`else
              state_q <= ST_ADDR1;
              rs_q    <= 1'b0;
              cmd_q   <= CMD_LINE1;
              start_q <= 1'b1;
`endif
            end else begin
              start_q <= 1'b1;
            end
          end
        end
`ifdef LCD_DIRTY_REFRESH_EN
        ST_IDLE: begin
          if (dirty_q) begin
            state_q <= ST_ADDR1;
            rs_q    <= 1'b0;
            cmd_q   <= CMD_LINE1;
            start_q <= 1'b1;
          end
        end
`endif
        default: state_q <= ST_PWR;
      endcase
    end
  end

  lcd_byte_writer #(
    .EN_CYC  (EN_CYC),
    .CMD_CYC (CMD_CYC),
    .CLR_CYC (CLR_CYC)
  ) u_writer (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_q),
    .rs_i        (rs_q),
    .data_i      (byte_d),
    .long_wait_i (long_q),
    .LCD_RS      (LCD_RS),
    .LCD_EN      (LCD_EN),
    .LCD_DATA    (LCD_DATA),
    .done_o      (wr_done)
  );

  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign LCD_ON     = ~rst;
  assign LCD_RW     = 1'b0;

endmodule

// File: tb/tb_lcd_text_controller.sv
// Directed bench for lcd_text_controller; LCD_DIRTY_REFRESH_EN adds the idle/dirty-refresh checks.
module tb_lcd_text_controller;

  localparam int POWERUP_CYC = 100;
  localparam int EN_CYC      = 2;
  localparam int CMD_CYC     = 10;
  localparam int CLR_CYC     = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, frame_done, LCD_ON, LCD_RS, LCD_EN, LCD_RW;
  logic [7:0] LCD_DATA;

  lcd_text_controller_if wr_bus ();

  lcd_text_controller #(
    .POWERUP_CYC (POWERUP_CYC),
    .EN_CYC      (EN_CYC),
    .CMD_CYC     (CMD_CYC),
    .CLR_CYC     (CLR_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_bus     (wr_bus),
    .init_done  (init_done),
    .frame_done (frame_done),
    .LCD_ON     (LCD_ON),
    .LCD_RS     (LCD_RS),
    .LCD_EN     (LCD_EN),
    .LCD_RW     (LCD_RW),
    .LCD_DATA   (LCD_DATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
    int         width;
  } xfer_t;

  xfer_t      xq[$];
  int         cyc = 0;
  int         hi_run = 0;
  int         en_hi_total = 0;
  int         fd_cnt = 0;
  int         fd_cyc = -1;
  int         init_cyc = -1;
  logic       prev_en = 1'b0;
  logic       prev_init = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] mdl [32];

  always @(posedge clk) cyc <= cyc + 1;

  // Each transfer is logged at its EN falling edge, with its EN-high width.
  always @(negedge clk) begin : mon
    xfer_t x;
    if (LCD_EN) begin
      hi_run      <= hi_run + 1;
      en_hi_total <= en_hi_total + 1;
    end else begin
      hi_run <= 0;
    end
    if (prev_en && !LCD_EN && !rst) begin
      x.rs    = LCD_RS;
      x.data  = LCD_DATA;
      x.cyc   = cyc;
      x.width = hi_run;
      xq.push_back(x);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (init_done && !prev_init) init_cyc <= cyc;
    prev_en   <= LCD_EN;
    prev_init <= init_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [4:0] addr, input logic [7:0] ch);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = addr;
    wr_bus.wr_char = ch;
    mdl[addr]      = ch;
    tick();
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (xq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(xq.size() >= n), 32'd1);
  endtask

  function automatic logic [8:0] exp_xfer(input int j);
    if (j == 0)  return {1'b0, 8'h80};
    if (j <= 16) return {1'b1, mdl[j-1]};
    if (j == 17) return {1'b0, 8'hC0};
    return {1'b1, mdl[j-2]};
  endfunction

  task automatic check_init(input int base, input string pfx);
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_cmd%0d", pfx, i), {xq[base+i].rs, xq[base+i].data}, {1'b0, cmds[i]});
      check($sformatf("%s_width%0d", pfx, i), xq[base+i].width, EN_CYC);
    end
    check($sformatf("%s_gap_38_0c", pfx), xq[base+1].cyc - xq[base].cyc, 3*EN_CYC + CMD_CYC);
    check($sformatf("%s_gap_01_06", pfx), xq[base+3].cyc - xq[base+2].cyc, 3*EN_CYC + CLR_CYC);
  endtask

  task automatic check_frame(input int base, input string pfx);
    for (int j = 0; j < 34; j++)
      check($sformatf("%s_x%0d", pfx, j), {xq[base+j].rs, xq[base+j].data}, exp_xfer(j));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int hi_base;
    int fd_base;
    int k;

    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_char = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

    repeat (3) tick();
    check("rst_on",     LCD_ON, 0);
    check("rst_en",     LCD_EN, 0);
    check("rst_rs",     LCD_RS, 0);
    check("rst_rw",     LCD_RW, 0);
    check("rst_data",   LCD_DATA, 8'h00);
    check("rst_init",   init_done, 0);
    check("rst_frame",  frame_done, 0);

    rst = 1'b0;
    hi_base = en_hi_total;
    tick();
    check("on_after_rst", LCD_ON, 1);
    write_char(5'd0, 8'h48);
    write_char(5'd17, 8'h69);
    repeat (96) tick();
    check("pwr_quiet", en_hi_total - hi_base, 0);

    wait_xfers(4, 600, "init_timeout");
    check_init(0, "init");
    wait_xfers(5, 100, "addr1_timeout");
    check("init_done_lat", init_cyc - xq[3].cyc, EN_CYC + CMD_CYC);
    check("init_done_hi", init_done, 1);

    wait_xfers(38, 800, "frame1_timeout");
    check_frame(4, "frame1");
    check("frame1_last_rw", LCD_RW, 0);
`ifdef LCD_DIRTY_REFRESH_EN
    write_char(5'd20, 8'h20);
`endif
    wait_xfers(39, 100, "frame2_start_timeout");
    check("frame2_addr1", {xq[38].rs, xq[38].data}, {1'b0, 8'h80});
    check("frame1_fd_count", fd_cnt, 1);
    check("frame1_fd_lat", fd_cyc - xq[37].cyc, EN_CYC + CMD_CYC - 1);

    // Write position 5 while its own transfer is in SETUP.
    wait_xfers(44, 200, "frame2_pos4_timeout");
    t = xq[43].cyc;
    k = 0;
    while (cyc < t + EN_CYC + CMD_CYC && k < 40) begin
      tick();
      k++;
    end
    check("pos5_setup_en", LCD_EN, 0);
    write_char(5'd5, 8'h41);
    wait_xfers(45, 100, "frame2_pos5_timeout");
    check("frame2_pos5_old", {xq[44].rs, xq[44].data}, {1'b1, 8'h20});

    wait_xfers(79, 800, "frame3_timeout");
    check("frame3_addr1", {xq[72].rs, xq[72].data}, {1'b0, 8'h80});
    check("frame3_pos0", {xq[73].rs, xq[73].data}, {1'b1, 8'h48});
    check("frame3_pos5_new", {xq[78].rs, xq[78].data}, {1'b1, 8'h41});

    // Asynchronous reset in the middle of a LINE1 EN pulse.
    wait_xfers(80, 100, "frame3_pos6_timeout");
    k = 0;
    while (!LCD_EN && k < 40) begin
      tick();
      k++;
    end
    check("pre_rst_en", LCD_EN, 1);
    check("pre_rst_rs", LCD_RS, 1);
    #2 rst = 1'b1;
    #1;
    check("async_en",   LCD_EN, 0);
    check("async_rs",   LCD_RS, 0);
    check("async_data", LCD_DATA, 8'h00);
    check("async_on",   LCD_ON, 0);
    check("async_init", init_done, 0);
    repeat (3) tick();
    check("async_frame", frame_done, 0);

    rst = 1'b0;
    xq.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    fd_base = fd_cnt;
    hi_base = en_hi_total;
    repeat (99) tick();
    check("pwr_quiet2", en_hi_total - hi_base, 0);
    wait_xfers(4, 600, "reinit_timeout");
    check_init(0, "reinit");
    wait_xfers(38, 800, "reframe_timeout");
    check_frame(4, "reframe");

`ifdef LCD_DIRTY_REFRESH_EN
    hi_base = en_hi_total;
    repeat (2000) tick();
    check("idle_no_en", en_hi_total - hi_base, 0);
    check("idle_no_xfer", xq.size(), 38);
    check("idle_fd_count", fd_cnt - fd_base, 1);
    write_char(5'd31, 8'h21);
    wait_xfers(72, 800, "dirty_frame_timeout");
    check("dirty_addr1", {xq[38].rs, xq[38].data}, {1'b0, 8'h80});
    check("dirty_pos31", {xq[71].rs, xq[71].data}, {1'b1, 8'h21});
    repeat (2000) tick();
    check("dirty_one_frame", xq.size(), 72);
    check("dirty_fd_count", fd_cnt - fd_base, 2);
`else
    wait_xfers(39, 100, "repeat_timeout");
    check("repeat_addr1", {xq[38].rs, xq[38].data}, {1'b0, 8'h80});
    check("repeat_fd_count", fd_cnt - fd_base, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
